// File: rtl/addr_window_map.sv
// Programmable address-window translator: shadow/active window sets with a
// bus-idle-gated commit FSM, and a two-stage decode pipeline.
module addr_window_map #(
    parameter int unsigned NUM_WIN = 4,
    parameter int unsigned AW      = 24
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [AW-1:0] SNES_ADDR_early,
    input  logic          SNES_WRITE_early,
    input  logic          addr_valid,
    input  logic          bus_idle,
    input  logic          cfg_we,
    input  logic [3:0]    cfg_win,
    input  logic [1:0]    cfg_field,
    input  logic [AW-1:0] cfg_data,
    input  logic          cfg_commit,
    output logic          commit_pending,
    output logic          commit_done,
    output logic [AW-1:0] ROM_ADDR,
    output logic          ROM_HIT,
    output logic          IS_WRITABLE,
    output logic [3:0]    WIN_IDX,
    output logic          hit_valid
);

    localparam int unsigned IW = 4;
    localparam logic [1:0] F_MATCH  = 2'd0;
    localparam logic [1:0] F_MASK   = 2'd1;
    localparam logic [1:0] F_TARGET = 2'd2;

    typedef enum logic {S_IDLE, S_PENDING} state_e;

    state_e state_q, state_d;
    logic   do_commit;
    logic   commit_done_q, commit_done_d;

    logic [AW-1:0] sh_match_q [NUM_WIN];
    logic [AW-1:0] sh_mask_q  [NUM_WIN];
    logic [AW-1:0] sh_tgt_q   [NUM_WIN];
    logic [1:0]    sh_ctrl_q  [NUM_WIN];
    logic [AW-1:0] ac_match_q [NUM_WIN];
    logic [AW-1:0] ac_mask_q  [NUM_WIN];
    logic [AW-1:0] ac_tgt_q   [NUM_WIN];
    logic [1:0]    ac_ctrl_q  [NUM_WIN];
    logic [AW-1:0] sh_match_d [NUM_WIN];
    logic [AW-1:0] sh_mask_d  [NUM_WIN];
    logic [AW-1:0] sh_tgt_d   [NUM_WIN];
    logic [1:0]    sh_ctrl_d  [NUM_WIN];
    logic [AW-1:0] ac_match_d [NUM_WIN];
    logic [AW-1:0] ac_mask_d  [NUM_WIN];
    logic [AW-1:0] ac_tgt_d   [NUM_WIN];
    logic [1:0]    ac_ctrl_d  [NUM_WIN];

    // Stage 1: registered address plus a snapshot of the winning window
    logic [AW-1:0]      addr_s1_q, addr_s1_d;
    logic               wr_s1_q, wr_s1_d;
    logic               valid_s1_q, valid_s1_d;
    logic [NUM_WIN-1:0] hit_s1_q, hit_s1_d;
    logic [IW-1:0]      sel_idx_q, sel_idx_d;
    logic [AW-1:0]      sel_tgt_q, sel_tgt_d;
    logic [AW-1:0]      sel_mask_q, sel_mask_d;
    logic               sel_wr_q, sel_wr_d;

    // Stage 2: decode outputs
    logic [AW-1:0] rom_addr_q, rom_addr_d;
    logic          rom_hit_q, rom_hit_d;
    logic          is_wr_q, is_wr_d;
    logic [IW-1:0] win_idx_q, win_idx_d;
    logic          hit_valid_q, hit_valid_d;

    // Write strobe is carried for alignment only; it does not affect decode
    logic unused_wr;
    assign unused_wr = wr_s1_q;

    // Commit FSM: commit on the first bus-idle cycle after a request
    always_comb begin
        state_d       = state_q;
        do_commit     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cfg_commit) begin
                    if (bus_idle) do_commit = 1'b1;
                    else          state_d   = S_PENDING;
                end
            end
            S_PENDING: begin
                if (bus_idle) begin
                    do_commit = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        commit_done_d = do_commit;
    end

    // Shadow writes and shadow-to-active copy (copy sees pre-write shadow)
    always_comb begin
        sh_match_d = sh_match_q;
        sh_mask_d  = sh_mask_q;
        sh_tgt_d   = sh_tgt_q;
        sh_ctrl_d  = sh_ctrl_q;
        ac_match_d = ac_match_q;
        ac_mask_d  = ac_mask_q;
        ac_tgt_d   = ac_tgt_q;
        ac_ctrl_d  = ac_ctrl_q;
        for (int i = 0; i < NUM_WIN; i++) begin
            if (cfg_we && (cfg_win == 4'(i))) begin
                case (cfg_field)
                    F_MATCH:  sh_match_d[i] = cfg_data;
                    F_MASK:   sh_mask_d[i]  = cfg_data;
                    F_TARGET: sh_tgt_d[i]   = cfg_data;
                    default:  sh_ctrl_d[i]  = cfg_data[1:0];
                endcase
            end
        end
        if (do_commit) begin
            ac_match_d = sh_match_q;
            ac_mask_d  = sh_mask_q;
            ac_tgt_d   = sh_tgt_q;
            ac_ctrl_d  = sh_ctrl_q;
        end
    end

    // Stage 1: per-window hit and lowest-index winner from the active set
    always_comb begin
        addr_s1_d  = SNES_ADDR_early;
        wr_s1_d    = SNES_WRITE_early;
        valid_s1_d = addr_valid;
        hit_s1_d   = '0;
        sel_idx_d  = '0;
        sel_tgt_d  = '0;
        sel_mask_d = '0;
        sel_wr_d   = 1'b0;
        for (int i = 0; i < NUM_WIN; i++) begin
            hit_s1_d[i] = ac_ctrl_q[i][0] &&
                          (((SNES_ADDR_early ^ ac_match_q[i]) & ac_mask_q[i]) == '0);
        end
        for (int i = NUM_WIN - 1; i >= 0; i--) begin
            if (hit_s1_d[i]) begin
                sel_idx_d  = 4'(i);
                sel_tgt_d  = ac_tgt_q[i];
                sel_mask_d = ac_mask_q[i];
                sel_wr_d   = ac_ctrl_q[i][1];
            end
        end
    end

    // Stage 2: translate or pass the address through
    always_comb begin
        rom_hit_d   = |hit_s1_q;
        rom_addr_d  = addr_s1_q;
        is_wr_d     = 1'b0;
        win_idx_d   = '0;
        hit_valid_d = valid_s1_q;
        if (rom_hit_d) begin
            rom_addr_d = sel_tgt_q + (addr_s1_q & ~sel_mask_q);
            is_wr_d    = sel_wr_q;
            win_idx_d  = sel_idx_q;
        end
    end

    // State, configuration and pipeline registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= S_IDLE;
            commit_done_q <= 1'b0;
            for (int i = 0; i < NUM_WIN; i++) begin
                sh_match_q[i] <= '0;
                sh_mask_q[i]  <= '0;
                sh_tgt_q[i]   <= '0;
                sh_ctrl_q[i]  <= '0;
                ac_match_q[i] <= '0;
                ac_mask_q[i]  <= '0;
                ac_tgt_q[i]   <= '0;
                ac_ctrl_q[i]  <= '0;
            end
            addr_s1_q   <= '0;
            wr_s1_q     <= 1'b0;
            valid_s1_q  <= 1'b0;
            hit_s1_q    <= '0;
            sel_idx_q   <= '0;
            sel_tgt_q   <= '0;
            sel_mask_q  <= '0;
            sel_wr_q    <= 1'b0;
            rom_addr_q  <= '0;
            rom_hit_q   <= 1'b0;
            is_wr_q     <= 1'b0;
            win_idx_q   <= '0;
            hit_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            commit_done_q <= commit_done_d;
            sh_match_q    <= sh_match_d;
            sh_mask_q     <= sh_mask_d;
            sh_tgt_q      <= sh_tgt_d;
            sh_ctrl_q     <= sh_ctrl_d;
            ac_match_q    <= ac_match_d;
            ac_mask_q     <= ac_mask_d;
            ac_tgt_q      <= ac_tgt_d;
            ac_ctrl_q     <= ac_ctrl_d;
            addr_s1_q     <= addr_s1_d;
            wr_s1_q       <= wr_s1_d;
            valid_s1_q    <= valid_s1_d;
            hit_s1_q      <= hit_s1_d;
            sel_idx_q     <= sel_idx_d;
            sel_tgt_q     <= sel_tgt_d;
            sel_mask_q    <= sel_mask_d;
            sel_wr_q      <= sel_wr_d;
            rom_addr_q    <= rom_addr_d;
            rom_hit_q     <= rom_hit_d;
            is_wr_q       <= is_wr_d;
            win_idx_q     <= win_idx_d;
            hit_valid_q   <= hit_valid_d;
        end
    end

    assign commit_pending = (state_q == S_PENDING);
    assign commit_done    = commit_done_q;
    assign ROM_ADDR       = rom_addr_q;
    assign ROM_HIT        = rom_hit_q;
    assign IS_WRITABLE    = is_wr_q;
    assign WIN_IDX        = win_idx_q;
    assign hit_valid      = hit_valid_q;

endmodule

// File: tb/tb_addr_window_map.sv
// Bench for addr_window_map: behavioural model checked every cycle, plus
// hand-computed literal expectations at key points.
module tb_addr_window_map;

    localparam int unsigned NW = 4;
    localparam int unsigned AW = 24;

    logic          CLK = 1'b0;
    logic          RST;
    logic [AW-1:0] SNES_ADDR_early;
    logic          SNES_WRITE_early;
    logic          addr_valid;
    logic          bus_idle;
    logic          cfg_we;
    logic [3:0]    cfg_win;
    logic [1:0]    cfg_field;
    logic [AW-1:0] cfg_data;
    logic          cfg_commit;
    logic          commit_pending;
    logic          commit_done;
    logic [AW-1:0] ROM_ADDR;
    logic          ROM_HIT;
    logic          IS_WRITABLE;
    logic [3:0]    WIN_IDX;
    logic          hit_valid;

    addr_window_map #(.NUM_WIN(NW), .AW(AW)) dut (
        .CLK(CLK), .RST(RST),
        .SNES_ADDR_early(SNES_ADDR_early), .SNES_WRITE_early(SNES_WRITE_early),
        .addr_valid(addr_valid), .bus_idle(bus_idle),
        .cfg_we(cfg_we), .cfg_win(cfg_win), .cfg_field(cfg_field),
        .cfg_data(cfg_data), .cfg_commit(cfg_commit),
        .commit_pending(commit_pending), .commit_done(commit_done),
        .ROM_ADDR(ROM_ADDR), .ROM_HIT(ROM_HIT), .IS_WRITABLE(IS_WRITABLE),
        .WIN_IDX(WIN_IDX), .hit_valid(hit_valid)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [AW-1:0] rom_addr;
        logic          hit;
        logic          wr;
        logic [3:0]    idx;
        logic          hv;
    } exp_t;

    // Model: shadow/active windows, pending flag, one decode in flight
    logic [AW-1:0] m_sm [NW];
    logic [AW-1:0] m_sk [NW];
    logic [AW-1:0] m_st [NW];
    logic [1:0]    m_sc [NW];
    logic [AW-1:0] m_am [NW];
    logic [AW-1:0] m_ak [NW];
    logic [AW-1:0] m_at [NW];
    logic [1:0]    m_ac [NW];
    logic          m_pend;
    logic          m_done;
    exp_t          m_stage;
    exp_t          m_out;

    int checks = 0;
    int errors = 0;

    function automatic exp_t decode(input logic [AW-1:0] a, input logic v);
        exp_t e;
        e          = '0;
        e.rom_addr = a;
        e.hv       = v;
        for (int w = 0; w < NW; w++) begin
            if (!e.hit && m_ac[w][0] && ((a & m_ak[w]) == (m_am[w] & m_ak[w]))) begin
                e.hit      = 1'b1;
                e.idx      = 4'(w);
                e.wr       = m_ac[w][1];
                e.rom_addr = m_at[w] + (a & ~m_ak[w]);
            end
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One clock: advance the model at the edge, then compare every output
    task automatic cyc();
        logic go;
        @(posedge CLK);
        if (RST) begin
            for (int w = 0; w < NW; w++) begin
                m_sm[w] = '0; m_sk[w] = '0; m_st[w] = '0; m_sc[w] = '0;
                m_am[w] = '0; m_ak[w] = '0; m_at[w] = '0; m_ac[w] = '0;
            end
            m_pend  = 1'b0;
            m_done  = 1'b0;
            m_stage = '0;
            m_out   = '0;
        end else begin
            m_out   = m_stage;
            m_stage = decode(SNES_ADDR_early, addr_valid);
            go      = m_pend || cfg_commit;
            m_done  = go && bus_idle;
            m_pend  = go && !bus_idle;
            if (m_done) begin
                for (int w = 0; w < NW; w++) begin
                    m_am[w] = m_sm[w]; m_ak[w] = m_sk[w];
                    m_at[w] = m_st[w]; m_ac[w] = m_sc[w];
                end
            end
            for (int w = 0; w < NW; w++) begin
                if (cfg_we && int'(cfg_win) == w) begin
                    case (cfg_field)
                        2'd0:    m_sm[w] = cfg_data;
                        2'd1:    m_sk[w] = cfg_data;
                        2'd2:    m_st[w] = cfg_data;
                        default: m_sc[w] = cfg_data[1:0];
                    endcase
                end
            end
        end
        #1;
        chk("rom_addr",       32'(ROM_ADDR),       32'(m_out.rom_addr));
        chk("rom_hit",        32'(ROM_HIT),        32'(m_out.hit));
        chk("is_writable",    32'(IS_WRITABLE),    32'(m_out.wr));
        chk("win_idx",        32'(WIN_IDX),        32'(m_out.idx));
        chk("hit_valid",      32'(hit_valid),      32'(m_out.hv));
        chk("commit_pending", 32'(commit_pending), 32'(m_pend));
        chk("commit_done",    32'(commit_done),    32'(m_done));
    endtask

    task automatic cfg(input logic [3:0] w, input logic [1:0] f, input logic [AW-1:0] d);
        cfg_we = 1'b1; cfg_win = w; cfg_field = f; cfg_data = d;
        cyc();
        cfg_we = 1'b0;
    endtask

    task automatic commit();
        cfg_commit = 1'b1;
        cyc();
        cfg_commit = 1'b0;
        chk("lit_commit_pulse", 32'(commit_done), 32'd1);
    endtask

    // Present one address; outputs for it are visible on return
    task automatic lookup(input logic [AW-1:0] a);
        SNES_ADDR_early = a;
        addr_valid      = 1'b1;
        cyc();
        addr_valid = 1'b0;
        cyc();
    endtask

    logic [AW-1:0] stream_tbl [4];

    initial begin
        stream_tbl[0] = 24'h0012F0; stream_tbl[1] = 24'h7E1234;
        stream_tbl[2] = 24'h001FFF; stream_tbl[3] = 24'hC00000;

        // Reset overrides simultaneous config write and commit
        RST = 1'b1; SNES_ADDR_early = 24'hC12345; SNES_WRITE_early = 1'b1;
        addr_valid = 1'b1; bus_idle = 1'b1;
        cfg_we = 1'b1; cfg_win = 4'd0; cfg_field = 2'd3; cfg_data = 24'h3;
        cfg_commit = 1'b1;
        cyc(); cyc();
        chk("lit_rst_hit",  32'(ROM_HIT),        32'd0);
        chk("lit_rst_addr", 32'(ROM_ADDR),       32'd0);
        chk("lit_rst_pend", 32'(commit_pending), 32'd0);
        RST = 1'b0; cfg_we = 1'b0; cfg_commit = 1'b0; addr_valid = 1'b0;
        cyc();
        chk("lit_post_rst_addr", 32'(ROM_ADDR),    32'd0);
        chk("lit_post_rst_done", 32'(commit_done), 32'd0);
        chk("lit_post_rst_hv",   32'(hit_valid),   32'd0);

        // Basic translation through window 0
        cfg(0, 0, 24'hC00000); cfg(0, 1, 24'hC00000);
        cfg(0, 2, 24'h400000); cfg(0, 3, 24'h1);
        commit();
        lookup(24'hC12345);
        chk("lit_basic_hit",  32'(ROM_HIT),   32'd1);
        chk("lit_basic_idx",  32'(WIN_IDX),   32'd0);
        chk("lit_basic_addr", 32'(ROM_ADDR),  32'h412345);
        chk("lit_basic_hv",   32'(hit_valid), 32'd1);
        lookup(24'h123456);
        chk("lit_miss_hit",  32'(ROM_HIT),  32'd0);
        chk("lit_miss_addr", 32'(ROM_ADDR), 32'h123456);

        // Priority: windows 0 and 2 both match
        cfg(0, 0, 24'h7E0000); cfg(0, 1, 24'hFF0000);
        cfg(0, 2, 24'h100000); cfg(0, 3, 24'h1);
        cfg(2, 0, 24'h7E1234); cfg(2, 1, 24'hFFFFFF);
        cfg(2, 2, 24'h200000); cfg(2, 3, 24'h3);
        commit();
        lookup(24'h7E1234);
        chk("lit_prio_idx",  32'(WIN_IDX),     32'd0);
        chk("lit_prio_wr",   32'(IS_WRITABLE), 32'd0);
        chk("lit_prio_addr", 32'(ROM_ADDR),    32'h101234);
        cfg(0, 3, 24'h0);
        commit();
        lookup(24'h7E1234);
        chk("lit_w2_idx",  32'(WIN_IDX),     32'd2);
        chk("lit_w2_wr",   32'(IS_WRITABLE), 32'd1);
        chk("lit_w2_addr", 32'(ROM_ADDR),    32'h200000);

        // Deferred commit: held off while the bus is busy, repeat absorbed
        cfg(0, 3, 24'h1);
        bus_idle = 1'b0; cfg_commit = 1'b1;
        cyc();
        cfg_commit = 1'b0;
        chk("lit_pend_set", 32'(commit_pending), 32'd1);
        cyc(); cyc();
        cfg_commit = 1'b1;
        cyc();
        cfg_commit = 1'b0;
        cyc();
        lookup(24'h7E1234);
        chk("lit_pend_old_idx", 32'(WIN_IDX),        32'd2);
        chk("lit_pend_still",   32'(commit_pending), 32'd1);
        bus_idle = 1'b1;
        cyc();
        chk("lit_pend_done",  32'(commit_done),    32'd1);
        chk("lit_pend_clear", 32'(commit_pending), 32'd0);
        cyc();
        chk("lit_pend_once", 32'(commit_done), 32'd0);
        lookup(24'h7E1234);
        chk("lit_pend_new_idx", 32'(WIN_IDX), 32'd0);

        // Config write on the commit edge lands in shadow only
        cfg_we = 1'b1; cfg_win = 4'd0; cfg_field = 2'd2; cfg_data = 24'h300000;
        cfg_commit = 1'b1;
        cyc();
        cfg_we = 1'b0; cfg_commit = 1'b0;
        lookup(24'h7E1234);
        chk("lit_prewrite_addr", 32'(ROM_ADDR), 32'h101234);
        commit();
        lookup(24'h7E1234);
        chk("lit_postwrite_addr", 32'(ROM_ADDR), 32'h301234);

        // Out-of-range window ignored; CTRL upper bits ignored
        cfg(4'd5, 3, 24'h3);
        cfg(2, 3, 24'hFFFFFD);
        cfg(0, 3, 24'h0);
        commit();
        lookup(24'h7E1234);
        chk("lit_ctrl_idx", 32'(WIN_IDX),     32'd2);
        chk("lit_ctrl_wr",  32'(IS_WRITABLE), 32'd0);

        // Target arithmetic and wrap-around
        cfg(1, 0, 24'h001000); cfg(1, 1, 24'hFFF000);
        cfg(1, 2, 24'hFFF000); cfg(1, 3, 24'h1);
        commit();
        lookup(24'h0012F0);
        chk("lit_top_addr", 32'(ROM_ADDR), 32'hFFF2F0);
        chk("lit_top_idx",  32'(WIN_IDX),  32'd1);
        cfg(1, 2, 24'hFFFF00);
        commit();
        lookup(24'h001200);
        chk("lit_wrap_addr", 32'(ROM_ADDR), 32'h000100);

        // Back-to-back stream with a commit mid-stream
        cfg(1, 2, 24'h050000);
        for (int i = 0; i < 12; i++) begin
            SNES_ADDR_early  = stream_tbl[i % 4];
            SNES_WRITE_early = i[0];
            addr_valid       = 1'b1;
            cfg_commit       = (i == 5);
            cyc();
        end
        cfg_commit = 1'b0; addr_valid = 1'b0;
        cyc(); cyc();

        // Reset while pending drops the commit
        bus_idle = 1'b0; cfg_commit = 1'b1;
        cyc();
        cfg_commit = 1'b0;
        chk("lit_rp_pend", 32'(commit_pending), 32'd1);
        RST = 1'b1;
        cyc();
        chk("lit_rp_pend_clr", 32'(commit_pending), 32'd0);
        chk("lit_rp_addr",     32'(ROM_ADDR),       32'd0);
        RST = 1'b0; bus_idle = 1'b1;
        cyc();
        chk("lit_rp_nodone0", 32'(commit_done), 32'd0);
        cyc();
        chk("lit_rp_nodone1", 32'(commit_done), 32'd0);
        lookup(24'h0012F0);
        chk("lit_rp_hit",  32'(ROM_HIT),  32'd0);
        chk("lit_rp_pass", 32'(ROM_ADDR), 32'h0012F0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
